// File: rtl/palette_engine_if.sv
// CPU palette write port: level request, address, data and accept pulse.
// The CPU side is the master; the palette is the slave.
interface palette_engine_if #(
    parameter int A_W = 10,
    parameter int D_W = 8
);
    logic           wr_req;
    logic [A_W-1:0] wr_addr;
    logic [D_W-1:0] wr_data;
    logic           wr_ack;

    modport master (
        output wr_req,
        output wr_addr,
        output wr_data,
        input  wr_ack
    );

    modport slave (
        input  wr_req,
        input  wr_addr,
        input  wr_data,
        output wr_ack
    );
endinterface

// File: rtl/palette_engine.sv
// CPU-writable colour palette: {bank,cref,col,vid} -> RGB lookup with
// global fade, blanking and a self-clearing RAM after reset.
module palette_engine #(
    parameter int COL_W  = 4,
    parameter int VID_W  = 2,
    parameter int CREF_W = 2,
    parameter int BANK_W = 2,
    parameter int R_W    = 3,
    parameter int G_W    = 3,
    parameter int B_W    = 2,
    parameter int FADE_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_en,
    input  logic              blank,
    input  logic [BANK_W-1:0] bank,
    input  logic [CREF_W-1:0] cref,
    input  logic [COL_W-1:0]  col,
    input  logic [VID_W-1:0]  vid,
    input  logic [FADE_W-1:0] fade,
    palette_engine_if.slave   wr,
    output logic              init_busy,
    output logic              video_valid,
    output logic [R_W-1:0]    r_sig,
    output logic [G_W-1:0]    g_sig,
    output logic [B_W-1:0]    b_sig
);
    localparam int A   = BANK_W + CREF_W + COL_W + VID_W;
    localparam int D_W = R_W + G_W + B_W;
    localparam int DEP = 1 << A;
    localparam int SW  = FADE_W + D_W;

    typedef enum logic [1:0] {INIT, IDLE, ACK} state_t;

    state_t         state_q;
    logic [A-1:0]   init_cnt_q;
    logic           init_busy_q;
    logic           wr_ack_q;

    logic [D_W-1:0] mem [DEP];
    logic           mem_we;
    logic [A-1:0]   mem_waddr;
    logic [D_W-1:0] mem_wdata;
    logic [A-1:0]   rd_addr;
    logic [D_W-1:0] rd_data;

    logic [D_W-1:0] rd_q, rd_d;
    logic           blank_s1_q, blank_s1_d;
    logic           blank_s2_q, blank_s2_d;
    logic           valid_q, valid_d;
    logic [R_W-1:0] r_q, r_d;
    logic [G_W-1:0] g_q, g_d;
    logic [B_W-1:0] b_q, b_d;

    // Saturating subtract done wide so fade >= 2^width clamps to zero.
    function automatic logic [SW-1:0] sat_sub(
        input logic [SW-1:0] c,
        input logic [SW-1:0] f
    );
        return (c > f) ? (c - f) : '0;
    endfunction

    // Control FSM: sweep-clear after reset, then one write per request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= INIT;
            init_cnt_q  <= '0;
            init_busy_q <= 1'b1;
            wr_ack_q    <= 1'b0;
        end else begin
            case (state_q)
                INIT: begin
                    wr_ack_q   <= 1'b0;
                    init_cnt_q <= init_cnt_q + 1'b1;
                    if (init_cnt_q == '1) begin
                        state_q     <= IDLE;
                        init_busy_q <= 1'b0;
                    end
                end
                IDLE: begin
                    if (wr.wr_req) begin
                        state_q  <= ACK;
                        wr_ack_q <= 1'b1;
                    end
                end
                ACK: begin
                    wr_ack_q <= 1'b0;
                    if (!wr.wr_req) state_q <= IDLE;
                end
                default: state_q <= INIT;
            endcase
        end
    end

    // Write port mux: clearing sweep owns the port while in INIT.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr.wr_addr;
        mem_wdata = wr.wr_data;
        if (state_q == INIT) begin
            mem_we    = 1'b1;
            mem_waddr = init_cnt_q;
            mem_wdata = '0;
        end else if (state_q == IDLE && wr.wr_req) begin
            mem_we = 1'b1;
        end
    end

    // Palette RAM write; the read below sees pre-edge (old) contents.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    // Next-state for the two pixel stages; everything holds without pix_en.
    always_comb begin
        rd_addr    = {bank, cref, col, vid};
        rd_data    = mem[rd_addr];
        rd_d       = rd_q;
        blank_s1_d = blank_s1_q;
        blank_s2_d = blank_s2_q;
        valid_d    = valid_q;
        r_d        = r_q;
        g_d        = g_q;
        b_d        = b_q;
        if (pix_en) begin
            rd_d       = init_busy_q ? '0 : rd_data;
            blank_s1_d = blank;
            blank_s2_d = blank_s1_q;
            valid_d    = ~blank_s1_q;
            if (blank_s1_q && blank_s2_q) begin
                r_d = '0;
                g_d = '0;
                b_d = '0;
            end else begin
                r_d = R_W'(sat_sub(SW'(rd_q[D_W-1 -: R_W]), SW'(fade)));
                g_d = G_W'(sat_sub(SW'(rd_q[B_W +: G_W]), SW'(fade)));
                b_d = B_W'(sat_sub(SW'(rd_q[B_W-1:0]), SW'(fade)));
            end
        end
    end

    // Pixel pipeline registers; blank flags reset to "blanked".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q       <= '0;
            blank_s1_q <= 1'b1;
            blank_s2_q <= 1'b1;
            valid_q    <= 1'b0;
            r_q        <= '0;
            g_q        <= '0;
            b_q        <= '0;
        end else begin
            rd_q       <= rd_d;
            blank_s1_q <= blank_s1_d;
            blank_s2_q <= blank_s2_d;
            valid_q    <= valid_d;
            r_q        <= r_d;
            g_q        <= g_d;
            b_q        <= b_d;
        end
    end

    assign wr.wr_ack   = wr_ack_q;
    assign init_busy   = init_busy_q;
    assign video_valid = valid_q;
    assign r_sig       = r_q;
    assign g_sig       = g_q;
    assign b_sig       = b_q;
endmodule

// File: tb/tb_palette_engine.sv
// Directed bench for palette_engine: clear sweep, writes, fade,
// blanking, same-cycle read/write, banks and mid-frame reset.
module tb_palette_engine;
    localparam int A   = 10;
    localparam int DEP = 1 << A;

    logic       clk = 1'b0;
    logic       rst;
    logic       pix_en;
    logic       blank;
    logic [1:0] bank;
    logic [1:0] cref;
    logic [3:0] col;
    logic [1:0] vid;
    logic [2:0] fade;
    logic       init_busy;
    logic       video_valid;
    logic [2:0] r_sig;
    logic [2:0] g_sig;
    logic [1:0] b_sig;

    int checks = 0;
    int errors = 0;

    palette_engine_if #(.A_W(A), .D_W(8)) wif ();

    palette_engine dut (
        .clk         (clk),
        .rst         (rst),
        .pix_en      (pix_en),
        .blank       (blank),
        .bank        (bank),
        .cref        (cref),
        .col         (col),
        .vid         (vid),
        .fade        (fade),
        .wr          (wif),
        .init_busy   (init_busy),
        .video_valid (video_valid),
        .r_sig       (r_sig),
        .g_sig       (g_sig),
        .b_sig       (b_sig)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pix(input logic [9:0] a, input logic bl);
        {bank, cref, col, vid} = a;
        blank = bl;
    endtask

    task automatic wait_init(output int n);
        n = 0;
        while (init_busy && n < 2000) begin
            tick();
            n++;
        end
    endtask

    task automatic do_write(input logic [9:0] a, input logic [7:0] d,
                            output int acks);
        acks = 0;
        wif.wr_addr = a;
        wif.wr_data = d;
        wif.wr_req  = 1'b1;
        repeat (5) begin
            tick();
            if (wif.wr_ack) acks++;
        end
        wif.wr_req = 1'b0;
        tick();
    endtask

    task automatic read_px(input logic [9:0] a, output logic [7:0] rgb,
                           output logic v);
        set_pix(a, 1'b0);
        pix_en = 1'b1;
        tick();
        tick();
        rgb = {r_sig, g_sig, b_sig};
        v   = video_valid;
    endtask

    task automatic test_reset();
        int n;
        int bad;
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({r_sig, g_sig, b_sig, video_valid} !== 9'd0) begin
            errors++;
            $display("FAIL reset_out got %0h want 0",
                     {r_sig, g_sig, b_sig, video_valid});
        end
        checks++;
        if ({init_busy, wif.wr_ack} !== 2'b10) begin
            errors++;
            $display("FAIL reset_ctl got %b want 10", {init_busy, wif.wr_ack});
        end
        rst = 1'b0;
        wait_init(n);
        checks++;
        if (n !== DEP) begin
            errors++;
            $display("FAIL init_len got %0d want %0d", n, DEP);
        end
        bad = 0;
        pix_en = 1'b1;
        for (int i = 0; i <= DEP; i++) begin
            set_pix(10'(i), 1'b0);
            tick();
            if (i >= 1 && ({r_sig, g_sig, b_sig} !== 8'd0 || !video_valid))
                bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL init_clear got %0d bad entries want 0", bad);
        end
    endtask

    task automatic test_write();
        int acks;
        logic [7:0] rgb;
        logic v;
        do_write(10'h025, 8'b101_110_01, acks);
        checks++;
        if (acks !== 1) begin
            errors++;
            $display("FAIL write_ack got %0d want 1", acks);
        end
        read_px(10'h025, rgb, v);
        checks++;
        if ({rgb, v} !== {8'b101_110_01, 1'b1}) begin
            errors++;
            $display("FAIL write_read got %0h/%b want b9/1", rgb, v);
        end
    endtask

    task automatic test_fade();
        int acks;
        logic [7:0] rgb;
        logic v;
        logic [2:0] fl [4] = '{3'd2, 3'd7, 3'd3, 3'd4};
        logic [7:0] ex [4] = '{8'b101_101_01, 8'b000_000_00,
                               8'b100_100_00, 8'b011_011_00};
        do_write(10'h010, 8'hff, acks);
        for (int i = 0; i < 4; i++) begin
            fade = fl[i];
            read_px(10'h010, rgb, v);
            checks++;
            if (rgb !== ex[i]) begin
                errors++;
                $display("FAIL fade_%0d got %0h want %0h", fl[i], rgb, ex[i]);
            end
        end
        fade = 3'd0;
    endtask

    task automatic test_blank();
        logic bl [11] = '{0, 0, 1, 0, 0, 1, 1, 1, 0, 0, 0};
        logic [7:0] ex [11] = '{8'hb9, 8'hb9, 8'hb9, 8'hb9, 8'hb9, 8'hb9,
                                8'h00, 8'h00, 8'hb9, 8'hb9, 8'hb9};
        logic ev [11] = '{1, 1, 0, 1, 1, 0, 0, 0, 1, 1, 1};
        pix_en = 1'b1;
        set_pix(10'h025, 1'b0);
        tick();
        tick();
        for (int j = 0; j < 11; j++) begin
            set_pix(10'h025, bl[j]);
            tick();
            if (j >= 1) begin
                checks++;
                if ({r_sig, g_sig, b_sig, video_valid} !== {ex[j-1], ev[j-1]}) begin
                    errors++;
                    $display("FAIL blank_px%0d got %0h/%b want %0h/%b", j - 1,
                             {r_sig, g_sig, b_sig}, video_valid, ex[j-1], ev[j-1]);
                end
            end
        end
        blank = 1'b0;
    endtask

    task automatic test_same_addr();
        set_pix(10'h025, 1'b0);
        pix_en = 1'b1;
        wif.wr_addr = 10'h025;
        wif.wr_data = 8'h3c;
        wif.wr_req  = 1'b1;
        tick();
        checks++;
        if (wif.wr_ack !== 1'b1) begin
            errors++;
            $display("FAIL same_ack got %b want 1", wif.wr_ack);
        end
        wif.wr_req = 1'b0;
        tick();
        checks++;
        if ({r_sig, g_sig, b_sig} !== 8'hb9) begin
            errors++;
            $display("FAIL same_old got %0h want b9", {r_sig, g_sig, b_sig});
        end
        tick();
        checks++;
        if ({r_sig, g_sig, b_sig} !== 8'h3c) begin
            errors++;
            $display("FAIL same_new got %0h want 3c", {r_sig, g_sig, b_sig});
        end
    endtask

    task automatic test_init_hold();
        int n;
        logic [7:0] rgb;
        logic v;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wif.wr_addr = 10'h030;
        wif.wr_data = 8'ha5;
        wif.wr_req  = 1'b1;
        n = 0;
        while (!wif.wr_ack && n < 2000) begin
            tick();
            n++;
        end
        checks++;
        if (n !== DEP + 1 || init_busy !== 1'b0) begin
            errors++;
            $display("FAIL init_hold_ack got %0d/%b want %0d/0", n, init_busy,
                     DEP + 1);
        end
        wif.wr_req = 1'b0;
        tick();
        read_px(10'h030, rgb, v);
        checks++;
        if (rgb !== 8'ha5) begin
            errors++;
            $display("FAIL init_hold_data got %0h want a5", rgb);
        end
        read_px(10'h025, rgb, v);
        checks++;
        if (rgb !== 8'h00) begin
            errors++;
            $display("FAIL reclear got %0h want 0", rgb);
        end
    endtask

    task automatic test_bank();
        int acks;
        logic [7:0] rgb;
        logic v;
        do_write(10'h025, 8'hb9, acks);
        do_write(10'h125, 8'b010_011_10, acks);
        read_px(10'h125, rgb, v);
        checks++;
        if (rgb !== 8'h4e) begin
            errors++;
            $display("FAIL bank1 got %0h want 4e", rgb);
        end
        read_px(10'h025, rgb, v);
        checks++;
        if (rgb !== 8'hb9) begin
            errors++;
            $display("FAIL bank0 got %0h want b9", rgb);
        end
    endtask

    task automatic test_mid_reset();
        int n;
        logic [7:0] rgb;
        logic v;
        read_px(10'h125, rgb, v);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({r_sig, g_sig, b_sig, video_valid, init_busy, wif.wr_ack}
            !== 11'b000_000_00_0_1_0) begin
            errors++;
            $display("FAIL mid_reset got %0h want 2",
                     {r_sig, g_sig, b_sig, video_valid, init_busy, wif.wr_ack});
        end
        tick();
        rst = 1'b0;
        wait_init(n);
        checks++;
        if (n !== DEP) begin
            errors++;
            $display("FAIL mid_init_len got %0d want %0d", n, DEP);
        end
        read_px(10'h125, rgb, v);
        checks++;
        if (rgb !== 8'h00) begin
            errors++;
            $display("FAIL mid_clear got %0h want 0", rgb);
        end
    endtask

    initial begin
        rst         = 1'b1;
        pix_en      = 1'b0;
        blank       = 1'b0;
        bank        = '0;
        cref        = '0;
        col         = '0;
        vid         = '0;
        fade        = '0;
        wif.wr_req  = 1'b0;
        wif.wr_addr = '0;
        wif.wr_data = '0;
        test_reset();
        test_write();
        test_fade();
        test_blank();
        test_same_addr();
        test_init_hold();
        test_bank();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
